// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned FLAG_W   = 3;

  localparam logic [ALU_OP_W-1:0] OP_ABS   = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SHL_B = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND   = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR    = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR   = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_NOT   = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_ADD   = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_SUB   = 3'd7;

  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_SIGN  = 1;
  localparam int unsigned FLAG_OV    = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Issues one command at a time to an external combinational ALU and returns its registered result.
// Optional sticky overflow flag: define ALU_SEQ_STICKY_OV_EN.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned OP_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [WIDTH-1:0]  cmd_a,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic              cmd_use_acc,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [WIDTH-1:0]  alu_z,
  input  logic              alu_carry,
  input  logic              alu_sign,
  input  logic              alu_ov,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [WIDTH-1:0]  res_z,
  output logic [FLAG_W-1:0] res_flags,
`ifdef ALU_SEQ_STICKY_OV_EN
  output logic              ov_sticky,
  input  logic              ov_clear,
`endif
  output logic [WIDTH-1:0]  acc
);

  seq_state_e state, state_nxt;
  logic       cmd_fire_c;
  logic       capture_c;

  // Next-state logic; cmd_ready is a registered copy of (state == IDLE)
  always_comb begin
    state_nxt  = state;
    cmd_fire_c = 1'b0;
    capture_c  = 1'b0;
    case (state)
      IDLE: begin
        cmd_fire_c = cmd_valid && cmd_ready;
        if (cmd_fire_c) state_nxt = ISSUE;
      end
      ISSUE: begin
        capture_c = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_z     <= '0;
      res_flags <= '0;
      acc       <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      res_valid <= (state_nxt == RESP);
      if (cmd_fire_c) begin
        alu_a  <= cmd_use_acc ? acc : cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
      end
      if (capture_c) begin
        res_z                 <= alu_z;
        res_flags[FLAG_CARRY] <= alu_carry;
        res_flags[FLAG_SIGN]  <= alu_sign;
        res_flags[FLAG_OV]    <= alu_ov;
        acc                   <= alu_z;
      end
    end
  end

`ifdef ALU_SEQ_STICKY_OV_EN
  // Set has priority over clear when both occur in one cycle
  always_ff @(posedge clk) begin
    if (rst)                     ov_sticky <= 1'b0;
    else if (capture_c && alu_ov) ov_sticky <= 1'b1;
    else if (ov_clear)           ov_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural 12-bit ALU beside the DUT.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic         cmd_use_acc;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_z;
  logic         alu_carry;
  logic         alu_sign;
  logic         alu_ov;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_z;
  logic [2:0]   res_flags;
  logic [W-1:0] acc;
`ifdef ALU_SEQ_STICKY_OV_EN
  logic         ov_sticky;
  logic         ov_clear;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(W), .OP_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_sign(alu_sign), .alu_ov(alu_ov),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_flags(res_flags),
`ifdef ALU_SEQ_STICKY_OV_EN
    .ov_sticky(ov_sticky), .ov_clear(ov_clear),
`endif
    .acc(acc)
  );

  // Behavioural ALU: returns {carry, sign, ov, z}
  function automatic logic [14:0] alu_model(input logic [2:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0]   t;
    logic [W-1:0] z;
    logic         c;
    logic         v;
    t = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ABS:   begin z = a[W-1] ? W'(-a) : a; v = (a == 12'h800); end
      OP_SHL_B: begin z = {b[W-2:0], 1'b0}; c = b[W-1]; end
      OP_AND:   z = a & b;
      OP_OR:    z = a | b;
      OP_XOR:   z = a ^ b;
      OP_NOT:   z = ~a;
      OP_ADD:   begin
        t = {1'b0, a} + {1'b0, b}; z = t[W-1:0]; c = t[W];
        v = (a[W-1] == b[W-1]) && (z[W-1] != a[W-1]);
      end
      default:  begin
        t = {1'b0, a} - {1'b0, b}; z = t[W-1:0]; c = t[W];
        v = (a[W-1] != b[W-1]) && (z[W-1] != a[W-1]);
      end
    endcase
    return {c, z[W-1], v, z};
  endfunction

  always_comb begin
    {alu_carry, alu_sign, alu_ov, alu_z} = alu_model(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Presents a command at negedge and returns right after the accepting edge (at the next negedge)
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ua);
    int budget;
    budget = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1;
    while (!cmd_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: cmd_ready stuck at 0, expected 1");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ua;
    logic [W-1:0] exp_z;
    logic [2:0]   exp_f;
  } vec_t;

  vec_t vecs[13];
  logic [W-1:0] hold_z, hold_a, hold_acc;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; res_ready = 1'b1;
`ifdef ALU_SEQ_STICKY_OV_EN
    ov_clear = 1'b0;
`endif
    // op, a, b, use_acc, expected z, expected {carry,sign,ov}
    vecs[0]  = '{OP_ADD,   12'h123, 12'h00A, 1'b1, 12'h00A, 3'b000}; // acc=0 after reset
    vecs[1]  = '{OP_ADD,   12'h7FF, 12'h001, 1'b0, 12'h800, 3'b011};
    vecs[2]  = '{OP_SUB,   12'h005, 12'h007, 1'b0, 12'hFFE, 3'b110};
    vecs[3]  = '{OP_ADD,   12'h010, 12'h020, 1'b0, 12'h030, 3'b000};
    vecs[4]  = '{OP_ADD,   12'hABC, 12'h005, 1'b1, 12'h035, 3'b000};
    vecs[5]  = '{OP_AND,   12'h0F0, 12'h0FF, 1'b0, 12'h0F0, 3'b000};
    vecs[6]  = '{OP_OR,    12'h555, 12'h00F, 1'b1, 12'h0FF, 3'b000};
    vecs[7]  = '{OP_XOR,   12'h0FF, 12'hFFF, 1'b0, 12'hF00, 3'b010};
    vecs[8]  = '{OP_NOT,   12'hF00, 12'h000, 1'b0, 12'h0FF, 3'b000};
    vecs[9]  = '{OP_ADD,   12'hFFF, 12'h001, 1'b0, 12'h000, 3'b100};
    vecs[10] = '{OP_SHL_B, 12'h000, 12'h801, 1'b0, 12'h002, 3'b100};
    vecs[11] = '{OP_ABS,   12'hFFB, 12'h000, 1'b0, 12'h005, 3'b000};
    vecs[12] = '{OP_SUB,   12'h000, 12'h005, 1'b1, 12'h000, 3'b000};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_acc",       32'(acc),       32'd0);
    chk("rst_res_z",     32'(res_z),     32'd0);
    chk("rst_alu_a",     32'(alu_a),     32'd0);

    // Table: one command each, res_ready high; result appears one cycle after ISSUE
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ua);
      chk($sformatf("v%0d_issue_res_valid", i), 32'(res_valid), 32'd0);
      chk($sformatf("v%0d_issue_cmd_ready", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].op));
      @(negedge clk);
      chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'd1);
      chk($sformatf("v%0d_res_z", i),     32'(res_z),     32'(vecs[i].exp_z));
      chk($sformatf("v%0d_res_flags", i), 32'(res_flags), 32'(vecs[i].exp_f));
      chk($sformatf("v%0d_acc", i),       32'(acc),       32'(vecs[i].exp_z));
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), 32'(cmd_ready), 32'd1);
    end

    // Backpressure: RESP held 10 cycles while the next command waits
    res_ready = 1'b0;
    send(OP_ADD, 12'h100, 12'h200, 1'b0);
    @(negedge clk);
    hold_z = res_z; hold_a = alu_a; hold_acc = acc;
    chk("bp_first_z", 32'(hold_z), 32'h300);
    cmd_op = OP_XOR; cmd_a = 12'h0F0; cmd_b = 12'h00F; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
      chk("bp_res_z",     32'(res_z),     32'(hold_z));
      chk("bp_alu_a",     32'(alu_a),     32'(hold_a));
      chk("bp_acc",       32'(acc),       32'(hold_acc));
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("bp_rel_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_alu_a", 32'(alu_a), 32'h0F0);
    chk("bp_next_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("bp_next_res_z", 32'(res_z), 32'h0FF);
    @(negedge clk);

    // Reset during ISSUE
    send(OP_ADD, 12'h111, 12'h222, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_issue_res_valid", 32'(res_valid), 32'd0);
    chk("rst_issue_acc",       32'(acc),       32'd0);
    chk("rst_issue_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_issue_alu_a",     32'(alu_a),     32'd0);
    @(negedge clk);
    chk("rst_issue_no_stale",  32'(res_valid), 32'd0);
    chk("rst_issue_res_z",     32'(res_z),     32'd0);

    // Reset during RESP
    res_ready = 1'b0;
    send(OP_ADD, 12'h333, 12'h111, 1'b0);
    @(negedge clk);
    chk("rresp_valid_before", 32'(res_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    chk("rst_resp_res_valid", 32'(res_valid), 32'd0);
    chk("rst_resp_acc",       32'(acc),       32'd0);
    chk("rst_resp_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_resp_flags",     32'(res_flags), 32'd0);
    @(negedge clk);
    chk("rst_resp_no_stale",  32'(res_valid), 32'd0);

`ifdef ALU_SEQ_STICKY_OV_EN
    do_reset();
    chk("sticky_rst", 32'(ov_sticky), 32'd0);
    send(OP_ADD, 12'h7FF, 12'h001, 1'b0);
    @(negedge clk);
    chk("sticky_set", 32'(ov_sticky), 32'd1);
    @(negedge clk);
    send(OP_AND, 12'h0F0, 12'h0FF, 1'b0);
    @(negedge clk);
    chk("sticky_hold_ov0", 32'(res_flags), 32'b000);
    chk("sticky_hold", 32'(ov_sticky), 32'd1);
    @(negedge clk);
    ov_clear = 1'b1;
    @(negedge clk);
    ov_clear = 1'b0;
    chk("sticky_clear", 32'(ov_sticky), 32'd0);
    // Set beats clear when the overflow capture coincides with ov_clear
    send(OP_SUB, 12'h800, 12'h001, 1'b0);
    ov_clear = 1'b1;
    @(negedge clk);
    ov_clear = 1'b0;
    chk("sticky_set_wins", 32'(ov_sticky), 32'd1);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
